// File: rtl/path_delay_sched.sv
// Inertial output-transition scheduler: applies rise, fall and high-Z delays to a single output.
// Define MINTYPMAX_SEL_EN to add the sel port, which chooses the min, typ or max delay corner.
module path_delay_sched #(
  parameter int T_RISE = 12,
  parameter int T_FALL = 22,
  parameter int T_Z    = 34,
  parameter int CW     = 6
`ifdef MINTYPMAX_SEL_EN
  ,
  parameter int T_RISE_MIN = 12,
  parameter int T_RISE_TYP = 14,
  parameter int T_RISE_MAX = 30,
  parameter int T_FALL_MIN = 16,
  parameter int T_FALL_TYP = 22,
  parameter int T_FALL_MAX = 40,
  parameter int T_Z_MIN    = 22,
  parameter int T_Z_TYP    = 30,
  parameter int T_Z_MAX    = 34
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_in,
  input  logic       oe_in,
`ifdef MINTYPMAX_SEL_EN
  input  logic [1:0] sel,
`endif
  output logic       q_out,
  output logic       q_oe,
  output logic       busy
);

  // state     | meaning
  // IDLE      | output matches target, nothing pending
  // RISE_WAIT | counting down to drive 1
  // FALL_WAIT | counting down to drive 0
  // Z_WAIT    | counting down to release (q_oe=0)
  typedef enum logic [1:0] {IDLE, RISE_WAIT, FALL_WAIT, Z_WAIT} state_t;

  // Counter load value: a delay of 0 acts as 1, and delays beyond the counter range saturate.
  function automatic logic [CW-1:0] load_of(input int t);
    int v;
    v = (t < 1) ? 1 : t;
    if (v > (1 << CW) - 1) v = (1 << CW) - 1;
    return CW'(v - 1);
  endfunction

`ifdef MINTYPMAX_SEL_EN
  localparam logic [CW-1:0] LD_RISE_MIN = load_of(T_RISE_MIN);
  localparam logic [CW-1:0] LD_RISE_TYP = load_of(T_RISE_TYP);
  localparam logic [CW-1:0] LD_RISE_MAX = load_of(T_RISE_MAX);
  localparam logic [CW-1:0] LD_FALL_MIN = load_of(T_FALL_MIN);
  localparam logic [CW-1:0] LD_FALL_TYP = load_of(T_FALL_TYP);
  localparam logic [CW-1:0] LD_FALL_MAX = load_of(T_FALL_MAX);
  localparam logic [CW-1:0] LD_Z_MIN    = load_of(T_Z_MIN);
  localparam logic [CW-1:0] LD_Z_TYP    = load_of(T_Z_TYP);
  localparam logic [CW-1:0] LD_Z_MAX    = load_of(T_Z_MAX);

  function automatic logic [CW-1:0] corner(input logic [1:0] s, input logic [CW-1:0] mn,
                                           input logic [CW-1:0] ty, input logic [CW-1:0] mx);
    case (s)
      2'd0:    return mn;
      2'd2:    return mx;
      default: return ty;
    endcase
  endfunction
`else
  localparam logic [CW-1:0] LD_RISE = load_of(T_RISE);
  localparam logic [CW-1:0] LD_FALL = load_of(T_FALL);
  localparam logic [CW-1:0] LD_Z    = load_of(T_Z);
`endif

  state_t        state, state_nx, tgt_state;
  logic [CW-1:0] cnt, cnt_nx, ld_val;
  logic          q_out_nx, q_oe_nx, tgt_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      q_out <= 1'b0;
      q_oe  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      q_out <= q_out_nx;
      q_oe  <= q_oe_nx;
    end
  end

  // q_out is a don't-care in the comparison whenever the output is released.
  assign tgt_match = (oe_in == q_oe) && (!oe_in || (d_in == q_out));
  assign tgt_state = !oe_in ? Z_WAIT : (d_in ? RISE_WAIT : FALL_WAIT);

  // sel only reaches the counter through ld_val, so it is sampled only when a wait is loaded.
  always_comb begin
    ld_val = '0;
    case (tgt_state)
`ifdef MINTYPMAX_SEL_EN
      RISE_WAIT: ld_val = corner(sel, LD_RISE_MIN, LD_RISE_TYP, LD_RISE_MAX);
      FALL_WAIT: ld_val = corner(sel, LD_FALL_MIN, LD_FALL_TYP, LD_FALL_MAX);
      default:   ld_val = corner(sel, LD_Z_MIN, LD_Z_TYP, LD_Z_MAX);
`else
      RISE_WAIT: ld_val = LD_RISE;
      FALL_WAIT: ld_val = LD_FALL;
      default:   ld_val = LD_Z;
`endif
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    q_out_nx = q_out;
    q_oe_nx  = q_oe;
    busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (!tgt_match) begin
          state_nx = tgt_state;
          cnt_nx   = ld_val;
        end
      end
      default: begin
        // A target change takes priority over expiry, so it cancels the pending event.
        if (tgt_match) begin
          state_nx = IDLE;
        end else if (tgt_state != state) begin
          state_nx = tgt_state;
          cnt_nx   = ld_val;
        end else if (cnt == '0) begin
          state_nx = IDLE;
          q_oe_nx  = (state != Z_WAIT);
          if (state != Z_WAIT) q_out_nx = (state == RISE_WAIT);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_path_delay_sched.sv
// Directed bench for path_delay_sched: a transition table plus hand sequences for cancellation,
// reset mid-wait, delay clamping and (with MINTYPMAX_SEL_EN) corner selection.
module tb_path_delay_sched;

`ifdef MINTYPMAX_SEL_EN
  localparam int ER = 14, EF = 22, EZ = 30;
`else
  localparam int ER = 12, EF = 22, EZ = 34;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic d_in = 1'b0, oe_in = 1'b0, d2 = 1'b0, oe2 = 1'b0;
  logic q_out, q_oe, busy, q_out2, q_oe2, busy2;
  logic [1:0] sel = 2'd1;
  logic [1:0] sel2 = 2'd1;

  always #5 clk = ~clk;

  path_delay_sched dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .oe_in(oe_in),
`ifdef MINTYPMAX_SEL_EN
    .sel(sel),
`endif
    .q_out(q_out), .q_oe(q_oe), .busy(busy)
  );

  // Second instance exercises the zero-delay and saturation boundaries.
`ifdef MINTYPMAX_SEL_EN
  path_delay_sched #(.T_RISE_TYP(0), .T_FALL_TYP(64), .T_Z_TYP(63)) dut2 (
    .clk(clk), .rst_n(rst_n), .d_in(d2), .oe_in(oe2), .sel(sel2),
    .q_out(q_out2), .q_oe(q_oe2), .busy(busy2)
  );
`else
  path_delay_sched #(.T_RISE(0), .T_FALL(64), .T_Z(63)) dut2 (
    .clk(clk), .rst_n(rst_n), .d_in(d2), .oe_in(oe2),
    .q_out(q_out2), .q_oe(q_oe2), .busy(busy2)
  );
`endif

  typedef struct {
    logic d;
    logic oe;
    int   dly;
    logic eq;
    logic eoe;
  } vec_t;

  vec_t vecs[10];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Edge 0 is the first rising edge after the call; returns the edge of the first output change or -1.
  task automatic measure(input bit which, input int max_edges, output int at_edge,
                         output bit busy_all, output bit busy_any);
    logic [1:0] snap;
    snap = which ? {q_oe2, q_out2} : {q_oe, q_out};
    at_edge = -1;
    busy_all = 1'b1;
    busy_any = 1'b0;
    for (int e = 0; e <= max_edges; e++) begin
      @(posedge clk); #1;
      if ((which ? {q_oe2, q_out2} : {q_oe, q_out}) !== snap) begin
        at_edge = e;
        return;
      end
      if ((which ? busy2 : busy) === 1'b1) busy_any = 1'b1;
      else busy_all = 1'b0;
    end
  endtask

  // Full transition on either instance: delay, final outputs, busy during and after.
  task automatic transition(input string name, input bit which, input logic d, input logic oe,
                            input int dly, input logic eq, input logic eoe);
    int at;
    bit ball, bany;
    @(negedge clk);
    if (which) begin d2 = d; oe2 = oe; end
    else begin d_in = d; oe_in = oe; end
    measure(which, (dly > 0) ? dly + 5 : 40, at, ball, bany);
    if (dly > 0) begin
      check({name, "_delay"}, at, dly);
      check({name, "_busy_during"}, ball, 1'b1);
    end else begin
      check({name, "_nochange"}, at, -1);
      check({name, "_busy_idle"}, bany, 1'b0);
    end
    check({name, "_q_out"}, which ? q_out2 : q_out, eq);
    check({name, "_q_oe"}, which ? q_oe2 : q_oe, eoe);
    check({name, "_busy_after"}, which ? busy2 : busy, 1'b0);
  endtask

  initial begin
    int at;
    bit ball, bany;

    vecs[0] = '{1'b1, 1'b1, ER, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b1, EF, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, EZ, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, EF, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, EZ, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, ER, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, EZ, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 0,  1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, ER, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 1'b1, EF, 1'b0, 1'b1};

    #2 rst_n = 1'b0;
    #5;
    check("reset_q_out", q_out, 1'b0);
    check("reset_q_oe", q_oe, 1'b0);
    check("reset_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      transition($sformatf("vec%0d", i), 1'b0, vecs[i].d, vecs[i].oe, vecs[i].dly,
                 vecs[i].eq, vecs[i].eoe);

    // Rise requested for 5 cycles then withdrawn: no output change, busy drops at edge 5.
    @(negedge clk);
    d_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("glitch_busy_e4", busy, 1'b1);
    d_in = 1'b0;
    @(posedge clk); #1;
    check("glitch_busy_e5", busy, 1'b0);
    measure(1'b0, 30, at, ball, bany);
    check("glitch_nochange", at, -1);
    check("glitch_q_out", q_out, 1'b0);
    check("glitch_q_oe", q_oe, 1'b1);

    // Rise at edge 0 retargeted to high-Z at edge 4: change only at edge 4+T_Z.
    @(negedge clk);
    d_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    oe_in = 1'b0;
    measure(1'b0, EZ + 10, at, ball, bany);
    check("retarget_edge", at + 4, 4 + EZ);
    check("retarget_busy", ball, 1'b1);
    check("retarget_q_oe", q_oe, 1'b0);
    check("retarget_q_out", q_out, 1'b0);

    // Reset asserted at edge 10 of a pending rise.
    @(negedge clk);
    d_in = 1'b1;
    oe_in = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    check("rst_mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_q_oe", q_oe, 1'b0);
    check("rst_mid_q_out", q_out, 1'b0);
    d_in = 1'b0;
    oe_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    measure(1'b0, 40, at, ball, bany);
    check("rst_after_nochange", at, -1);
    check("rst_after_busy", bany, 1'b0);
    transition("rst_then_rise", 1'b0, 1'b1, 1'b1, ER, 1'b1, 1'b1);

    transition("clamp_zero_rise", 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    transition("clamp_sat_fall", 1'b1, 1'b0, 1'b1, 63, 1'b0, 1'b1);
    transition("clamp_max_z", 1'b1, 1'b0, 1'b0, 63, 1'b0, 1'b0);

`ifdef MINTYPMAX_SEL_EN
    sel = 2'd0;
    transition("sel0_fall", 1'b0, 1'b0, 1'b1, 16, 1'b0, 1'b1);
    sel = 2'd3;
    transition("sel3_z", 1'b0, 1'b0, 1'b0, 30, 1'b0, 1'b0);
    sel = 2'd2;
    transition("sel2_rise", 1'b0, 1'b1, 1'b1, 30, 1'b1, 1'b1);
    @(negedge clk);
    sel = 2'd0;
    d_in = 1'b0;
    @(posedge clk); #1;
    sel = 2'd2;
    measure(1'b0, 50, at, ball, bany);
    check("sel_mid_wait_delay", at + 1, 16);
    check("sel_mid_wait_q_out", q_out, 1'b0);
    sel = 2'd1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/path_delay_sched.md
PATH_DELAY_SCHED -- requirements
Module: path_delay_sched

Interface
REQ-001 SHALL have parameter T_RISE, default 12; cycles for a 0->1 or z->1 output transition.
REQ-002 SHALL have parameter T_FALL, default 22; cycles for a 1->0 or z->0 output transition.
REQ-003 SHALL have parameter T_Z, default 34; cycles for a driven->z transition.
REQ-004 SHALL have parameter CW, default 6; delay counter width.
REQ-005 SHALL have port clk, input, 1 bit; single clock, all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit; asynchronous active-low reset.
REQ-007 SHALL have port d_in, input, 1 bit; requested output data value.
REQ-008 SHALL have port oe_in, input, 1 bit; requested drive enable (0 = high-impedance request).
REQ-009 SHALL have port q_out, output, 1 bit; delayed data value, meaningful when q_oe=1.
REQ-010 SHALL have port q_oe, output, 1 bit; delayed drive enable.
REQ-011 SHALL have port busy, output, 1 bit; 1 while a transition is pending.
REQ-012 SHALL have port sel, input, 2 bits, only when MINTYPMAX_SEL_EN is defined; delay corner select.

Function
REQ-013 SHALL hold a target {oe_in, d_in} compared each cycle against the current output {q_oe, q_out}, with q_out ignored when q_oe=0.
REQ-014 SHALL implement states IDLE, RISE_WAIT, FALL_WAIT and Z_WAIT.
REQ-015 SHALL leave IDLE when the target differs from the output at an edge. It SHALL pick the next state by target:
- oe=0: Z_WAIT
- oe=1, d=1: RISE_WAIT
- oe=1, d=0: FALL_WAIT
REQ-016 SHALL load the counter with the selected delay minus 1 on entry to a WAIT state, and decrement it each cycle.
REQ-017 SHALL update the output and return to IDLE at the edge where the counter reaches 0.
REQ-018 SHALL make the output change exactly N edges after the edge that detected the change, where N is the selected delay.
REQ-019 SHALL treat a delay of 0 as 1.
REQ-020 SHALL saturate delay values that exceed 2^CW-1 to 2^CW-1.
REQ-021 SHALL apply inertial behaviour when the target changes during a WAIT state:
- pending event is cancelled
- if the new target equals the current output, return to IDLE with no output change
- otherwise enter the WAIT state for the new target and reload the counter the same edge
REQ-022 SHALL apply the z->driven transition as q_oe and q_out updating together after T_RISE when d_in=1, or after T_FALL when d_in=0.
REQ-023 SHALL, on a driven->z transition, clear only q_oe after T_Z and hold q_out at its last value.
REQ-024 SHALL assert busy in every WAIT state and deassert it in IDLE, combinationally from the state.

Reset
REQ-025 SHALL, while rst_n=0, immediately force state=IDLE, counter=0, q_out=0, q_oe=0 and busy=0, independent of clk.
REQ-026 SHALL discard any pending transition on reset assertion mid-wait.
REQ-027 SHALL, after rst_n rises, evaluate the target at the first rising clk edge.

Configuration
REQ-028 SHALL use macro MINTYPMAX_SEL_EN to enable selectable min/typ/max delay corners.
REQ-029 SHALL, with MINTYPMAX_SEL_EN defined, add parameters T_RISE_MIN/TYP/MAX = 12/14/30, T_FALL_MIN/TYP/MAX = 16/22/40 and T_Z_MIN/TYP/MAX = 22/30/34, and add the sel port.
REQ-030 SHALL decode sel as 0=min, 1=typ, 2=max, with 3 treated as typ.
REQ-031 SHALL sample sel only when loading the counter; a sel change during a wait SHALL NOT affect that wait.
REQ-032 SHALL, without MINTYPMAX_SEL_EN, have no sel port and use T_RISE, T_FALL and T_Z.

Verification
REQ-033 SHALL cover: reset, then oe_in=1, d_in=1 applied at edge 0 -> q_oe=1 and q_out=1 at edge 12, busy=1 for edges 0..11.
REQ-034 SHALL cover: driven 1, d_in=0 at edge 0 -> q_out=0 at edge 22; driven 0, oe_in=0 -> q_oe=0 at edge 34 with q_out held at 0.
REQ-035 SHALL cover: driven 0, d_in=1 for 5 cycles then back to 0 -> no output change, busy drops at edge 5.
REQ-036 SHALL cover: driven 0, d_in=1 at edge 0, then oe_in=0 at edge 4 -> rise cancelled, q_oe=0 at edge 38, q_out stays 0.
REQ-037 SHALL cover, with MINTYPMAX_SEL_EN: sel=2 rise -> 30 cycles; sel=0 fall -> 16 cycles; sel=3 z -> 30 cycles; sel changed mid-wait -> delay unchanged.
REQ-038 SHALL cover: rst_n pulsed low at edge 10 of a pending rise -> q_oe=0, q_out=0 and busy=0 immediately, with no later output change until a new target is detected.
